// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 bit mux with registered grant, select and data.
// Optional per-owner hold limit compiled in with `define MUX_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       y,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       y_q, y_d;

  logic [3:0] others;
  logic [3:0] mask;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       hold_expired;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end
  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_HOLD");
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  // The current owner is excluded from the search so a rotation never re-picks it.
  assign others = req & ~gnt_q;
  assign mask   = (state_q == GRANT) ? others : req;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    y_d     = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'(1) << win;
          sel_d   = win;
          last_d  = win;
          y_d     = din[win];
`ifdef MUX_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (req[sel_q] && !(hold_expired && (others != 4'b0000))) begin
          y_d = din[sel_q];
`ifdef MUX_ARB_HOLD_LIMIT_EN
          if (!hold_expired) cnt_d = cnt_q + 1'b1;
`endif
        end else if (found) begin
          gnt_d  = 4'(1) << win;
          sel_d  = win;
          last_d = win;
          y_d    = din[win];
`ifdef MUX_ARB_HOLD_LIMIT_EN
          cnt_d  = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      y_q     <= y_d;
    end
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign y    = y_q;
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: driver queues expected outputs, monitor checks each edge.
// Hold-limit expectations follow `define MUX_ARB_HOLD_LIMIT_EN (bench uses MAX_HOLD=4).
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       busy;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .sel  (sel),
    .y    (y),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = {gnt, sel, y, busy};
    total_cnt++;
    if (a === e) begin
      pass_cnt++;
      $display("ok   %-12s gnt=%b sel=%0d y=%b busy=%b", nm, a.gnt, a.sel, a.y, a.busy);
    end else begin
      $display("FAIL %-12s got gnt=%b sel=%0d y=%b busy=%b, want gnt=%b sel=%0d y=%b busy=%b",
               nm, a.gnt, a.sel, a.y, a.busy, e.gnt, e.sel, e.y, e.busy);
    end
  endtask

  // Drive inputs before the edge and queue what the outputs must show after it.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                      input logic [1:0] es, input logic ey, input string nm);
    exp_t e;
    @(negedge clk);
    req = r;
    din = d;
    e = {eg, es, ey, (eg != 4'b0000)};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;
    #1;
    check("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // first grant and asynchronous reset while granted
    step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "grant2");
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "hold2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("async_rst", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // rotation 0,1,2,3,0 with owners dropping in turn
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, "rr0");
    step(4'b1110, 4'b1010, 4'b0010, 2'd1, 1'b1, "rr1");
    step(4'b1101, 4'b1010, 4'b0100, 2'd2, 1'b0, "rr2");
    step(4'b1011, 4'b1010, 1000,    2'd3, 1'b1, "rr3");
    step(4'b0111, 4'b1010, 4'b0001, 2'd0, 1'b0, "rr0b");
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, "rr_hold");
    step(4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, "rr_idle");

    // y tracks din[1] while owner 1 holds
    step(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, "y1_a");
    step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, "y1_b");
    step(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, "y1_c");
    step(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, "y1_idle");

    // simultaneous requests from last=1, then set last=3
    step(4'b1111, 4'b1000, 4'b0100, 2'd2, 1'b0, "simul");
    step(4'b0000, 4'b1000, 4'b0000, 2'd2, 1'b0, "simul_idle");
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, "g3");
    step(4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, "g3_idle");
    step(4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b0, "last3_1010");
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, "handoff3");
    step(4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, "ho_idle");

    // owner 0 held while 2 waits
    for (int k = 0; k < 7; k++) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (k < 4) step(4'b0101, 4'b0101, 4'b0001, 2'd0, 1'b1, "hold_lim0");
      else       step(4'b0101, 4'b0101, 4'b0100, 2'd2, 1'b1, "hold_lim2");
`else
      step(4'b0101, 4'b0101, 4'b0001, 2'd0, 1'b1, "hold_nolim");
`endif
    end
    step(4'b0100, 4'b0101, 4'b0100, 2'd2, 1'b1, "hold_drop");
    step(4'b0000, 4'b0101, 4'b0000, 2'd2, 1'b0, "hold_idle");

    // lone requester keeps the grant indefinitely
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, "solo");
    end
    step(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "solo_idle");

    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
